// File: rtl/seq_root_div.sv
// seq_root_div
//   Sequential signed divider / non-negative integer square root. One
//   operation runs at a time through the states IDLE -> LOAD -> CALC -> DONE.
//   Each CALC cycle performs one restoring iteration. Mode 1 takes
//   WORD_LENGTH iterations and mode 0 takes WORD_LENGTH/2.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     begins an operation; sampled only in IDLE
//   mode      0 = floor(sqrt(x_input)), 1 = x_input / d_input
//   x_input   signed radicand / dividend, captured when start is accepted
//   d_input   signed divisor, captured when start is accepted (unused in mode 0)
//   y_output  root or quotient (truncated toward zero), registered
//   r_output  root remainder or division remainder (sign of dividend), registered
//   busy      high in LOAD and CALC
//   done      one-cycle pulse in DONE
//   error     status of the last completed operation, registered

module seq_root_div #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic signed [WORD_LENGTH-1:0] x_input,
    input  logic signed [WORD_LENGTH-1:0] d_input,
    output logic signed [WORD_LENGTH-1:0] y_output,
    output logic signed [WORD_LENGTH-1:0] r_output,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_n;

    // Magnitude of a two's-complement value. The most negative value maps to
    // 2^(W-1), which still fits in W unsigned bits.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
        return v[W-1] ? (~v + W'(1)) : v;
    endfunction

    // Re-apply a sign to an unsigned magnitude. A quotient magnitude of 2^(W-1)
    // with a negative sign wraps to the most negative value, which is correct.
    function automatic logic signed [W-1:0] apply_sign(input logic [W-1:0] m,
                                                        input logic       neg);
        logic signed [W-1:0] s;
        s = $signed(m);
        return neg ? -s : s;
    endfunction

    // Captured operands. These are data only and carry no reset.
    logic                mode_q;
    logic signed [W-1:0] x_q;
    logic signed [W-1:0] d_q;

    // Working registers. shf_q holds the dividend or radicand magnitude being
    // shifted out MSB-first, res_q collects result bits, and rem_q is the
    // partial remainder.
    logic [W:0]    rem_q;
    logic [W-1:0]  shf_q;
    logic [W-1:0]  res_q;
    logic [CW-1:0] cnt_q;

    logic          op_err;
    logic          last_iter;
    logic [CW-1:0] n_iter;
    logic [W-1:0]  d_mag;
    logic [W+1:0]  rem_s;
    logic [W+1:0]  trial;
    logic [W:0]    rem_n;
    logic [W-1:0]  shf_n;
    logic [W-1:0]  res_n;
    logic          qbit;
    logic signed [W-1:0] y_fin;
    logic signed [W-1:0] r_fin;

    always_comb begin
        d_mag     = magnitude(d_q);
        n_iter    = mode_q ? CW'(W) : CW'(W / 2);
        last_iter = (cnt_q == n_iter - CW'(1));
        if (mode_q) begin
            op_err = (d_q == '0) || ((x_q == MOST_NEG) && (d_q == '1));
        end else begin
            op_err = x_q[W-1];
        end
    end

    // One restoring iteration. Division brings down one dividend bit and
    // subtracts |d|. Square root brings down two radicand bits and subtracts
    // (4*root + 1). A non-negative trial sets the result bit and keeps the
    // difference; otherwise the shifted remainder is restored.
    always_comb begin
        if (mode_q) begin
            rem_s = {rem_q, shf_q[W-1]};
            trial = rem_s - {2'b00, d_mag};
            shf_n = {shf_q[W-2:0], 1'b0};
        end else begin
            rem_s = {rem_q[W-1:0], shf_q[W-1:W-2]};
            trial = rem_s - {res_q, 2'b01};
            shf_n = {shf_q[W-3:0], 2'b00};
        end
        qbit  = ~trial[W+1];
        rem_n = qbit ? trial[W:0] : rem_s[W:0];
        res_n = {res_q[W-2:0], qbit};
        if (mode_q) begin
            y_fin = apply_sign(res_n, x_q[W-1] ^ d_q[W-1]);
            r_fin = apply_sign(rem_n[W-1:0], x_q[W-1]);
        end else begin
            y_fin = $signed(res_n);
            r_fin = $signed(rem_n[W-1:0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_n = op_err ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            y_output <= '0;
            r_output <= '0;
            error    <= 1'b0;
        end else begin
            if (state == LOAD) begin
                cnt_q <= '0;
            end else if (state == CALC) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if ((state == LOAD) && op_err) begin
                y_output <= '0;
                r_output <= '0;
                error    <= 1'b1;
            end else if ((state == CALC) && last_iter) begin
                y_output <= y_fin;
                r_output <= r_fin;
                error    <= 1'b0;
            end
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && start) begin
            mode_q <= mode;
            x_q    <= x_input;
            d_q    <= d_input;
        end
        if (state == LOAD) begin
            rem_q <= '0;
            res_q <= '0;
            shf_q <= magnitude(x_q);
        end else if (state == CALC) begin
            rem_q <= rem_n;
            res_q <= res_n;
            shf_q <= shf_n;
        end
    end

endmodule

// File: tb/tb_seq_root_div.sv
module tb_seq_root_div;

    localparam int W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                mode;
    logic signed [W-1:0] x_input;
    logic signed [W-1:0] d_input;
    logic signed [W-1:0] y_output;
    logic signed [W-1:0] r_output;
    logic                busy;
    logic                done;
    logic                error;

    int n_checks = 0;
    int n_fail   = 0;

    seq_root_div #(.WORD_LENGTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .x_input  (x_input),
        .d_input  (d_input),
        .y_output (y_output),
        .r_output (r_output),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // busy and done must never be high together
    always @(negedge clk) begin
        if (done) chk("busy_done_excl", int'(busy), 0);
    end

    // Reference results from plain integer arithmetic
    function automatic void model(input bit m, input int x, input int d,
                                  output int y, output int r, output bit e);
        y = 0; r = 0; e = 1'b0;
        if (!m) begin
            if (x < 0) begin
                e = 1'b1;
            end else begin
                while ((y + 1) * (y + 1) <= x) y++;
                r = x - y * y;
            end
        end else begin
            if (d == 0 || (x == -(1 << (W - 1)) && d == -1)) begin
                e = 1'b1;
            end else begin
                y = x / d;
                r = x % d;
            end
        end
    endfunction

    task automatic run_op(input bit m, input int x, input int d, input bit poke);
        int ey, er, edges, exp_lat;
        bit ee;
        model(m, x, d, ey, er, ee);
        exp_lat = ee ? 1 : (m ? W + 1 : W / 2 + 1);
        @(posedge clk) #1;
        mode    = m;
        x_input = x[W-1:0];
        d_input = d[W-1:0];
        start   = 1'b1;
        @(posedge clk) #1;
        start   = 1'b0;
        x_input = $urandom_range(0, 255);
        d_input = $urandom_range(0, 255);
        mode    = $urandom_range(0, 1);
        chk("busy_load", int'(busy), 1);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk) #1;
            edges++;
            if (poke && edges == 2) begin
                start   = 1'b1;
                x_input = ~x_input;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("latency", edges, exp_lat);
        chk("y", int'(y_output), ey);
        chk("r", int'(r_output), er);
        chk("err", int'(error), int'(ee));
        @(posedge clk) #1;
        chk("done_pulse", int'(done), 0);
        chk("hold_y", int'(y_output), ey);
    endtask

    initial begin
        int x, d, cnt;
        bit m;
        reset   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        x_input = '0;
        d_input = '0;
        #1;
        chk("rst_y", int'(y_output), 0);
        chk("rst_r", int'(r_output), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(error), 0);
        #12 reset = 1'b1;

        run_op(1'b0, 100, 0, 1'b0);
        run_op(1'b0, 120, 0, 1'b0);
        run_op(1'b0, -4, 0, 1'b0);
        run_op(1'b0, 0, 0, 1'b0);
        run_op(1'b0, 127, 0, 1'b0);
        run_op(1'b1, -100, 7, 1'b0);
        run_op(1'b1, 100, -7, 1'b0);
        run_op(1'b1, 5, 0, 1'b0);
        run_op(1'b1, -128, -1, 1'b0);
        run_op(1'b1, -128, 1, 1'b0);
        run_op(1'b1, -128, -128, 1'b0);
        run_op(1'b1, 127, -128, 1'b0);
        run_op(1'b1, 77, 9, 1'b1);
        run_op(1'b0, 99, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 1);
            x = int'($urandom_range(0, 255)) - 128;
            d = int'($urandom_range(0, 255)) - 128;
            if (!m && $urandom_range(0, 3) != 0) x = $urandom_range(0, 127);
            run_op(m, x, d, $urandom_range(0, 1));
        end

        // Reset mid-CALC, asserted between clock edges
        run_op(1'b1, 100, -7, 1'b0);
        @(posedge clk) #1;
        mode = 1'b1; x_input = 8'sd50; d_input = 8'sd3; start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_y", int'(y_output), 0);
        chk("arst_r", int'(r_output), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_err", int'(error), 0);
        cnt = 0;
        repeat (12) begin
            @(posedge clk) #1;
            if (done) cnt++;
        end
        @(posedge clk) #4 reset = 1'b1;
        repeat (12) begin
            @(posedge clk) #1;
            if (done) cnt++;
        end
        chk("no_done_after_abort", cnt, 0);
        run_op(1'b1, 127, 127, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
